// File: rtl/spm_pkg.sv
// Shared definitions for the spm serial-parallel multiplier and its driver:
// default operand width, controller state encoding and counter sizing.
package spm_pkg;

    localparam int SPM_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bit-counter width needed to count the 2*size serial cycles.
    function automatic int cntWidth(input int sz);
        return $clog2(2 * sz);
    endfunction

    localparam int CNT_W = cntWidth(SPM_SIZE);

endpackage

// File: rtl/spm_driver_if.sv
// Bundles the requester-side start/done bus and the link to one spm instance.
// The driver sees everything through the slave modport. The requester uses the
// master modport. The multiplier uses the spm modport.
interface spm_driver_if
    import spm_pkg::*;
#(
    parameter int size = SPM_SIZE
);

    logic                  start;
    logic [size-1:0]       a;
    logic [size-1:0]       b;
    logic                  busy;
    logic                  done;
    logic [2*size-1:0]     prod;
    logic [size-1:0]       spm_x;
    logic                  spm_y;
    logic                  spm_ld;
    logic                  spm_p;

    modport slave (
        input  start, a, b, spm_p,
        output busy, done, prod, spm_x, spm_y, spm_ld
    );

    modport master (
        output start, a, b,
        input  busy, done, prod
    );

    modport spm (
        input  spm_x, spm_y, spm_ld,
        output spm_p
    );

endinterface

// File: rtl/spm.sv
// Serial-parallel two's complement multiplier.
// x is held in parallel. y arrives LSB first, already sign-extended by the sender.
// One product bit leaves per cycle on a registered p, so bit s shows up during cycle s+1.
// ld=1 holds the running partial sum cleared.
module spm #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] x,
    input  logic            y,
    input  logic            ld,
    output logic            p
);

    // Two guard bits keep x + partial sum exact, including the most negative x.
    logic signed [size+1:0] r_acc;
    logic signed [size+1:0] w_addend;
    logic signed [size+1:0] w_sum;
    logic                   r_p;

    assign w_addend = y ? {{2{x[size-1]}}, x} : '0;
    assign w_sum    = r_acc + w_addend;
    assign p        = r_p;

    // Add the selected partial product, emit the settled LSB, and keep the rest arithmetically shifted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_p   <= 1'b0;
        end else if (ld) begin
            r_acc <= '0;
            r_p   <= 1'b0;
        end else begin
            r_acc <= w_sum >>> 1;
            r_p   <= w_sum[0];
        end
    end

endmodule

// File: rtl/spm_driver.sv
// Operand serializer and product collector for one spm instance.
// A start latches a and b. The module presents a in parallel and streams b
// LSB first with sign extension for 2*size cycles. It gathers the serial product
// into prod and pulses done.
module spm_driver
    import spm_pkg::*;
#(
    parameter int size = SPM_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    spm_driver_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam int                  CNT_WL   = cntWidth(size);
    localparam logic [CNT_WL-1:0]   LAST_CNT = CNT_WL'(2 * size - 1);

    logic [1:0]          r_state;
    logic [CNT_WL-1:0]   r_cnt;
    logic [size-1:0]     r_x;
    logic [size-1:0]     r_b;
    logic [2*size-1:0]   r_prod;
    logic                w_accept;
    logic                w_capture;

    // A request is only honoured between operations. The first SHIFT cycle carries
    // no product bit yet, so collection starts one cycle late and ends in DRAIN.
    assign w_accept  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.start;
    assign w_capture = ((r_state == ST_SHIFT) && (r_cnt != '0)) || (r_state == ST_DRAIN);

    assign bus.busy   = (r_state == ST_SHIFT) || (r_state == ST_DRAIN);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.spm_ld = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign bus.spm_y  = (r_state == ST_SHIFT) ? r_b[0] : 1'b0;
    assign bus.spm_x  = r_x;
    assign bus.prod   = r_prod;

    // Sequence IDLE -> SHIFT (2*size cycles) -> DRAIN -> DONE, counting serial cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (w_accept) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Latch the operands on acceptance. Shifting b right with MSB replication sign-extends the stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_b <= '0;
        end else if (w_accept) begin
            r_x <= bus.a;
            r_b <= bus.b;
        end else if (r_state == ST_SHIFT) begin
            r_b <= {r_b[size-1], r_b[size-1:1]};
        end
    end

    // Shift each incoming product bit in at the MSB so the last capture leaves bit 0 in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
        end else if (w_capture) begin
            r_prod <= {bus.spm_p, r_prod[2*size-1:1]};
        end
    end

endmodule
